water_lamp: RTL and testbench

- Car rear-lamp controller.
- Drives two 3-LED groups: left (ledL) and right (ledR).
  - Turn inputs produce sequential ("water") turn patterns.
  - Brake forces all lamps on.
  - An open door produces hazard blinking.
- Two 7-segment digits show how many seconds the door has been open.
- Top-level lamp block; inputs come directly from board switches, outputs go directly to LEDs and segments.

---
 rtl/water_lamp.sv | 162 ++++++++++++++++
 tb/tb_water_lamp.sv | 128 ++++++++++++
 2 files changed

// File: rtl/water_lamp.sv
// Car rear-lamp controller: sequential turn patterns, brake override, door hazard blink and door-open seconds display.
// Define SEG_ACTIVE_LOW_EN to invert the segment outputs for common-anode digits.
module water_lamp #(
   parameter int unsigned STEP_CYCLES = 25000000,
   parameter int unsigned SEC_STEPS   = 2
) (
   input  logic       clk,
   input  logic       rstN,
   input  logic       rstL,
   input  logic       rstR,
   input  logic       rstBrake,
   input  logic       rstDoor,
   output logic [2:0] ledL,
   output logic [2:0] ledR,
   output logic [6:0] ledNum1,
   output logic [6:0] ledNum2
);

   localparam int unsigned CW = $clog2(STEP_CYCLES);
   localparam int unsigned SW = (SEC_STEPS > 1) ? $clog2(SEC_STEPS) : 1;
   localparam logic [CW-1:0] CNT_MAX  = CW'(STEP_CYCLES - 1);
   localparam logic [SW-1:0] STEP_MAX = SW'(SEC_STEPS - 1);

`ifdef SEG_ACTIVE_LOW_EN
   localparam logic [6:0] SEG_POL = '1;
`else
   localparam logic [6:0] SEG_POL = '0;
`endif

   typedef enum logic [1:0] {
      MODE_TURN,
      MODE_HAZARD,
      MODE_BRAKE
   } lampMode_t;

   logic [CW-1:0] preCnt;
   logic          tick;
   logic [1:0]    phaseL, phaseR;
   logic          hazOff;
   logic [SW-1:0] stepCnt;
   logic [3:0]    secTens, secUnits;

   logic [1:0]    phaseLNext, phaseRNext;
   logic          hazOffNext;
   logic [SW-1:0] stepNext;
   logic [3:0]    tensNext, unitsNext;
   logic          secWrap;
   lampMode_t     mode;
   logic [2:0]    ledLNext, ledRNext;
   logic [6:0]    num1Next, num2Next;

   function automatic logic [2:0] turnPattern(input logic [1:0] ph);
      case (ph)
         2'd0:    turnPattern = 3'b001;
         2'd1:    turnPattern = 3'b011;
         2'd2:    turnPattern = 3'b111;
         default: turnPattern = 3'b000;
      endcase
   endfunction

   function automatic logic [6:0] segOf(input logic [3:0] d);
      case (d)
         4'd0:    segOf = 7'b0111111;
         4'd1:    segOf = 7'b0000110;
         4'd2:    segOf = 7'b1011011;
         4'd3:    segOf = 7'b1001111;
         4'd4:    segOf = 7'b1100110;
         4'd5:    segOf = 7'b1101101;
         4'd6:    segOf = 7'b1111101;
         4'd7:    segOf = 7'b0000111;
         4'd8:    segOf = 7'b1111111;
         4'd9:    segOf = 7'b1101111;
         default: segOf = 7'b0000000;
      endcase
   endfunction

   // Outputs are registered from next-state values so a tick shows 1 clk after it.
   always_comb begin
      phaseLNext = rstL ? (phaseL + {1'b0, tick}) : '0;
      phaseRNext = rstR ? (phaseR + {1'b0, tick}) : '0;
      hazOffNext = rstDoor & (hazOff ^ tick);
      secWrap    = rstDoor & tick & (stepCnt == STEP_MAX);

      stepNext = stepCnt;
      if (!rstDoor) begin
         stepNext = '0;
      end else if (tick) begin
         stepNext = (stepCnt == STEP_MAX) ? '0 : stepCnt + 1'b1;
      end

      tensNext  = secTens;
      unitsNext = secUnits;
      if (!rstDoor) begin
         tensNext  = '0;
         unitsNext = '0;
      end else if (secWrap) begin
         if (secUnits == 4'd9) begin
            unitsNext = '0;
            tensNext  = (secTens == 4'd9) ? 4'd0 : secTens + 4'd1;
         end else begin
            unitsNext = secUnits + 4'd1;
         end
      end

      if (rstBrake) begin
         mode = MODE_BRAKE;
      end else if (rstDoor) begin
         mode = MODE_HAZARD;
      end else begin
         mode = MODE_TURN;
      end

      case (mode)
         MODE_BRAKE: begin
            ledLNext = 3'b111;
            ledRNext = 3'b111;
         end
         MODE_HAZARD: begin
            ledLNext = {3{~hazOffNext}};
            ledRNext = {3{~hazOffNext}};
         end
         default: begin
            ledLNext = rstL ? turnPattern(phaseLNext) : 3'b000;
            ledRNext = rstR ? turnPattern(phaseRNext) : 3'b000;
         end
      endcase

      num1Next = (rstDoor ? segOf(tensNext)  : 7'b0000000) ^ SEG_POL;
      num2Next = (rstDoor ? segOf(unitsNext) : 7'b0000000) ^ SEG_POL;
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         preCnt   <= '0;
         tick     <= 1'b0;
         phaseL   <= '0;
         phaseR   <= '0;
         hazOff   <= 1'b0;
         stepCnt  <= '0;
         secTens  <= '0;
         secUnits <= '0;
         ledL     <= '0;
         ledR     <= '0;
         ledNum1  <= SEG_POL;
         ledNum2  <= SEG_POL;
      end else begin
         preCnt   <= (preCnt == CNT_MAX) ? '0 : preCnt + 1'b1;
         tick     <= (preCnt == CNT_MAX);
         phaseL   <= phaseLNext;
         phaseR   <= phaseRNext;
         hazOff   <= hazOffNext;
         stepCnt  <= stepNext;
         secTens  <= tensNext;
         secUnits <= unitsNext;
         ledL     <= ledLNext;
         ledR     <= ledRNext;
         ledNum1  <= num1Next;
         ledNum2  <= num2Next;
      end
   end

endmodule

// File: tb/tb_water_lamp.sv
// Table-driven bench for water_lamp with STEP_CYCLES=4, SEC_STEPS=2.
module tb_water_lamp;

   logic       clk = 1'b0;
   logic       rstN, rstL, rstR, rstBrake, rstDoor;
   logic [2:0] ledL, ledR;
   logic [6:0] ledNum1, ledNum2;

   int unsigned checks = 0;
   int unsigned errors = 0;

`ifdef SEG_ACTIVE_LOW_EN
   localparam logic [6:0] SEGINV = '1;
`else
   localparam logic [6:0] SEGINV = '0;
`endif
   localparam logic [6:0] BLK = 7'b0000000;
   localparam logic [6:0] S0  = 7'b0111111;
   localparam logic [6:0] S1  = 7'b0000110;
   localparam logic [6:0] S9  = 7'b1101111;

   typedef struct {
      string       name;
      logic        l, r, b, d;
      int unsigned waitCyc;
      logic [2:0]  eL, eR;
      logic [6:0]  e1, e2;
   } vec_t;

   vec_t vecs[$];

   water_lamp #(.STEP_CYCLES(4), .SEC_STEPS(2)) dut (
      .clk(clk), .rstN(rstN), .rstL(rstL), .rstR(rstR),
      .rstBrake(rstBrake), .rstDoor(rstDoor),
      .ledL(ledL), .ledR(ledR), .ledNum1(ledNum1), .ledNum2(ledNum2)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input string name, input logic l, r, b, d,
                               input int unsigned w, input logic [2:0] eL, eR,
                               input logic [6:0] e1, e2);
      vec_t v;
      v.name = name; v.l = l; v.r = r; v.b = b; v.d = d; v.waitCyc = w;
      v.eL = eL; v.eR = eR; v.e1 = e1; v.e2 = e2;
      return v;
   endfunction

   task automatic check(input string name, input logic [2:0] eL, eR, input logic [6:0] e1, e2);
      logic [6:0] w1, w2;
      w1 = e1 ^ SEGINV;
      w2 = e2 ^ SEGINV;
      checks++;
      if ({ledL, ledR, ledNum1, ledNum2} !== {eL, eR, w1, w2}) begin
         errors++;
         $display("FAIL %s: got L=%b R=%b N1=%b N2=%b, want L=%b R=%b N1=%b N2=%b",
                  name, ledL, ledR, ledNum1, ledNum2, eL, eR, w1, w2);
      end
   endtask

   task automatic drive(input logic l, r, b, d);
      rstL = l; rstR = r; rstBrake = b; rstDoor = d;
   endtask

   task automatic cycles(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      // Edge numbers (E<n>) count posedges after reset release; tick effects land on E5, E9, ...
      vecs.push_back(mk("left_on",        1,0,0,0,   1, 3'b001,3'b000,BLK,BLK)); // E1
      vecs.push_back(mk("left_hold",      1,0,0,0,   3, 3'b001,3'b000,BLK,BLK)); // E4
      vecs.push_back(mk("left_p1",        1,0,0,0,   1, 3'b011,3'b000,BLK,BLK)); // E5
      vecs.push_back(mk("left_p2",        1,0,0,0,   4, 3'b111,3'b000,BLK,BLK)); // E9
      vecs.push_back(mk("left_p3",        1,0,0,0,   4, 3'b000,3'b000,BLK,BLK)); // E13
      vecs.push_back(mk("left_p0",        1,0,0,0,   4, 3'b001,3'b000,BLK,BLK)); // E17
      vecs.push_back(mk("both_on",        1,1,0,0,   1, 3'b001,3'b001,BLK,BLK)); // E18
      vecs.push_back(mk("both_p1",        1,1,0,0,   3, 3'b011,3'b011,BLK,BLK)); // E21
      vecs.push_back(mk("brake_on",       1,1,1,0,   1, 3'b111,3'b111,BLK,BLK)); // E22
      vecs.push_back(mk("brake_hold",     1,1,1,0,   8, 3'b111,3'b111,BLK,BLK)); // E30, phase 3
      vecs.push_back(mk("brake_off_p3",   1,1,0,0,   1, 3'b000,3'b000,BLK,BLK)); // E31
      vecs.push_back(mk("resume_p0",      1,1,0,0,   2, 3'b001,3'b001,BLK,BLK)); // E33
      vecs.push_back(mk("turn_off",       0,0,0,0,   1, 3'b000,3'b000,BLK,BLK)); // E34
      vecs.push_back(mk("idle",           0,0,0,0,  11, 3'b000,3'b000,BLK,BLK)); // E45
      vecs.push_back(mk("door_open",      0,0,0,1,   1, 3'b111,3'b111,S0,S0));   // E46
      vecs.push_back(mk("haz_toggle",     0,0,0,1,   3, 3'b000,3'b000,S0,S0));   // E49
      vecs.push_back(mk("door_sec1",      0,0,0,1,   4, 3'b111,3'b111,S0,S1));   // E53
      vecs.push_back(mk("door_sec10",     0,0,0,1,  72, 3'b111,3'b111,S1,S0));   // E125
      vecs.push_back(mk("door_sec99",     0,0,0,1, 712, 3'b111,3'b111,S9,S9));   // E837
      vecs.push_back(mk("door_wrap00",    0,0,0,1,   8, 3'b111,3'b111,S0,S0));   // E845
      vecs.push_back(mk("door_close",     0,0,0,0,   1, 3'b000,3'b000,BLK,BLK)); // E846
      vecs.push_back(mk("brake_door",     0,0,1,1,   1, 3'b111,3'b111,S0,S0));   // E847
      vecs.push_back(mk("brake_door_s1",  0,0,1,1,   6, 3'b111,3'b111,S0,S1));   // E853
      vecs.push_back(mk("brake_rel_haz",  0,0,0,1,   4, 3'b000,3'b000,S0,S1));   // E857

      rstN = 1'b0;
      drive(1, 1, 1, 1);
      cycles(2);
      check("reset_all_high", 3'b000, 3'b000, BLK, BLK);

      rstN = 1'b1;
      drive(0, 0, 0, 0);
      foreach (vecs[i]) begin
         drive(vecs[i].l, vecs[i].r, vecs[i].b, vecs[i].d);
         cycles(vecs[i].waitCyc);
         check(vecs[i].name, vecs[i].eL, vecs[i].eR, vecs[i].e1, vecs[i].e2);
      end

      // Asynchronous reset mid-operation, then restart from phase 0 and time 00.
      #2 rstN = 1'b0;
      #1 check("mid_reset", 3'b000, 3'b000, BLK, BLK);
      cycles(1);
      rstN = 1'b1;
      drive(1, 0, 0, 0);
      cycles(1);
      check("restart_p0", 3'b001, 3'b000, BLK, BLK);
      cycles(4);
      check("restart_p1", 3'b011, 3'b000, BLK, BLK);
      drive(1, 0, 0, 1);
      cycles(1);
      check("restart_door00", 3'b111, 3'b111, S0, S0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
